// File: rtl/mem_access_unit_pkg.sv
// Shared definitions for the memory access unit: FSM state encoding and default widths.
package mem_access_unit_pkg;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    REQ  = 2'd1,
    DONE = 2'd2
  } state_t;

  localparam int DEFAULT_DATA_WIDTH     = 32;
  localparam int DEFAULT_ADDR_WIDTH     = 32;
  localparam int DEFAULT_TIMEOUT_CYCLES = 15;

endpackage

// File: rtl/mem_timeout_counter.sv
// Counts REQ cycles that pass without an acknowledge and flags the terminal cycle.
module mem_timeout_counter #(
  parameter int TIMEOUT_CYCLES = 15
) (
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic enable,
  output logic expired
);

  logic [7:0] count;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= 8'd0;
    end else if (clear) begin
      count <= 8'd0;
    end else if (enable) begin
      count <= count + 8'd1;
    end
  end

  // Flag the cycle whose unacknowledged increment would reach the limit.
  assign expired = (count == 8'(TIMEOUT_CYCLES - 1));

endmodule

// File: rtl/mem_access_unit.sv
// Sequences single load/store transactions over a req/ack memory port.
// Optional wait timeout is enabled by defining MEM_TIMEOUT_EN.
module mem_access_unit
  import mem_access_unit_pkg::*;
#(
  parameter int DATA_WIDTH     = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH     = DEFAULT_ADDR_WIDTH,
  parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
  input  logic                  CLOCK_50,
  input  logic                  RESET_InHigh,
  input  logic                  IN_START,
  input  logic                  IN_WRITE,
  input  logic [ADDR_WIDTH-1:0] IN_ADDR,
  input  logic [DATA_WIDTH-1:0] IN_WDATA,
  output logic                  OUT_BUSY,
  output logic                  OUT_DONE,
  output logic [DATA_WIDTH-1:0] OUT_RDATA,
  output logic                  OUT_SELECT_MEM,
  output logic                  OUT_ERROR,
  output logic                  MEM_REQ,
  output logic                  MEM_WE,
  output logic [ADDR_WIDTH-1:0] MEM_ADDR,
  output logic [DATA_WIDTH-1:0] MEM_WDATA,
  input  logic                  MEM_ACK,
  input  logic [DATA_WIDTH-1:0] MEM_RDATA
);

  state_t state, state_next;

  logic                  busy_next;
  logic                  done_next;
  logic [DATA_WIDTH-1:0] rdata_next;
  logic                  select_next;
  logic                  error_next;
  logic                  req_next;
  logic                  we_next;
  logic [ADDR_WIDTH-1:0] addr_next;
  logic [DATA_WIDTH-1:0] wdata_next;
  logic                  timeout_hit;

`ifdef MEM_TIMEOUT_EN
  logic timeout_clear;
  logic timeout_enable;
  logic timeout_expired;

  assign timeout_clear  = (state == IDLE) && IN_START;
  assign timeout_enable = (state == REQ) && !MEM_ACK;

  mem_timeout_counter #(
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_timeout (
    .clk    (CLOCK_50),
    .rst    (RESET_InHigh),
    .clear  (timeout_clear),
    .enable (timeout_enable),
    .expired(timeout_expired)
  );

  // An acknowledge in the terminal cycle wins, so only a missing ack can time out.
  assign timeout_hit = timeout_enable && timeout_expired;
`else
  assign timeout_hit = 1'b0;
`endif

  // Next-state and next-output logic; every output is registered below.
  always_comb begin
    state_next  = state;
    req_next    = MEM_REQ;
    we_next     = MEM_WE;
    addr_next   = MEM_ADDR;
    wdata_next  = MEM_WDATA;
    rdata_next  = OUT_RDATA;
    done_next   = 1'b0;
    select_next = 1'b0;
    error_next  = 1'b0;

    case (state)
      IDLE: begin
        if (IN_START) begin
          we_next    = IN_WRITE;
          addr_next  = IN_ADDR;
          wdata_next = IN_WDATA;
          req_next   = 1'b1;
          state_next = REQ;
        end
      end
      REQ: begin
        if (MEM_ACK) begin
          if (!MEM_WE) begin
            rdata_next = MEM_RDATA;
          end
          req_next    = 1'b0;
          done_next   = 1'b1;
          select_next = !MEM_WE;
          state_next  = DONE;
        end else if (timeout_hit) begin
          req_next   = 1'b0;
          done_next  = 1'b1;
          error_next = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        req_next   = 1'b0;
        state_next = IDLE;
      end
    endcase

    busy_next = (state_next != IDLE);
  end

  always_ff @(posedge CLOCK_50 or posedge RESET_InHigh) begin
    if (RESET_InHigh) begin
      state          <= IDLE;
      OUT_BUSY       <= 1'b0;
      OUT_DONE       <= 1'b0;
      OUT_RDATA      <= '0;
      OUT_SELECT_MEM <= 1'b0;
      OUT_ERROR      <= 1'b0;
      MEM_REQ        <= 1'b0;
      MEM_WE         <= 1'b0;
      MEM_ADDR       <= '0;
      MEM_WDATA      <= '0;
    end else begin
      state          <= state_next;
      OUT_BUSY       <= busy_next;
      OUT_DONE       <= done_next;
      OUT_RDATA      <= rdata_next;
      OUT_SELECT_MEM <= select_next;
      OUT_ERROR      <= error_next;
      MEM_REQ        <= req_next;
      MEM_WE         <= we_next;
      MEM_ADDR       <= addr_next;
      MEM_WDATA      <= wdata_next;
    end
  end

endmodule

// File: tb/tb_mem_access_unit.sv
// Scoreboard bench for mem_access_unit; timeout scenarios run when MEM_TIMEOUT_EN is defined.
module tb_mem_access_unit;

  localparam int DW = 32;
  localparam int AW = 32;
`ifdef MEM_TIMEOUT_EN
  localparam int TO = 4;
`else
  localparam int TO = 15;
`endif

  typedef struct packed {
    logic [DW-1:0] rdata;
    logic          select;
    logic          error;
  } exp_t;

  logic          CLOCK_50 = 1'b0;
  logic          RESET_InHigh;
  logic          IN_START;
  logic          IN_WRITE;
  logic [AW-1:0] IN_ADDR;
  logic [DW-1:0] IN_WDATA;
  logic          OUT_BUSY;
  logic          OUT_DONE;
  logic [DW-1:0] OUT_RDATA;
  logic          OUT_SELECT_MEM;
  logic          OUT_ERROR;
  logic          MEM_REQ;
  logic          MEM_WE;
  logic [AW-1:0] MEM_ADDR;
  logic [DW-1:0] MEM_WDATA;
  logic          MEM_ACK;
  logic [DW-1:0] MEM_RDATA;

  exp_t          exp_q[$];
  exp_t          exp_item;
  logic [DW-1:0] model_rdata;
  int            check_count = 0;
  int            fail_count  = 0;

  mem_access_unit #(
    .DATA_WIDTH    (DW),
    .ADDR_WIDTH    (AW),
    .TIMEOUT_CYCLES(TO)
  ) dut (
    .CLOCK_50      (CLOCK_50),
    .RESET_InHigh  (RESET_InHigh),
    .IN_START      (IN_START),
    .IN_WRITE      (IN_WRITE),
    .IN_ADDR       (IN_ADDR),
    .IN_WDATA      (IN_WDATA),
    .OUT_BUSY      (OUT_BUSY),
    .OUT_DONE      (OUT_DONE),
    .OUT_RDATA     (OUT_RDATA),
    .OUT_SELECT_MEM(OUT_SELECT_MEM),
    .OUT_ERROR     (OUT_ERROR),
    .MEM_REQ       (MEM_REQ),
    .MEM_WE        (MEM_WE),
    .MEM_ADDR      (MEM_ADDR),
    .MEM_WDATA     (MEM_WDATA),
    .MEM_ACK       (MEM_ACK),
    .MEM_RDATA     (MEM_RDATA)
  );

  always #5 CLOCK_50 = ~CLOCK_50;

  task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
    check_count++;
    if (observed !== expected) begin
      fail_count++;
      $display("[TB] FAIL %s: got 0x%08h, want 0x%08h", tag, observed, expected);
    end
  endtask

  // Every completion pulse must match the oldest outstanding expectation.
  always @(negedge CLOCK_50) begin
    if (RESET_InHigh === 1'b0 && OUT_DONE === 1'b1) begin
      if (exp_q.size() == 0) begin
        checkOutput("spurious_done", {31'b0, OUT_DONE}, 32'd0);
      end else begin
        exp_item = exp_q.pop_front();
        checkOutput("sb_rdata", OUT_RDATA, exp_item.rdata);
        checkOutput("sb_select_mem", {31'b0, OUT_SELECT_MEM}, {31'b0, exp_item.select});
        checkOutput("sb_error", {31'b0, OUT_ERROR}, {31'b0, exp_item.error});
      end
    end
  end

  // One transaction: ack arrives in REQ cycle ack_delay+1, or never when give_ack=0.
  task automatic applyStimulus(input logic write, input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                               input int ack_delay, input logic [DW-1:0] rdata, input logic give_ack,
                               input logic noise);
    @(negedge CLOCK_50);
    IN_START = 1'b1;
    IN_WRITE = write;
    IN_ADDR  = addr;
    IN_WDATA = wdata;
    if (give_ack && !write) model_rdata = rdata;
    exp_q.push_back('{rdata: model_rdata, select: give_ack && !write, error: !give_ack});
    for (int i = 0; i <= ack_delay; i++) begin
      @(negedge CLOCK_50);
      IN_START = noise;
      if (noise) IN_ADDR = ~addr;
      checkOutput("req_high", {31'b0, MEM_REQ}, 32'd1);
      checkOutput("busy_high", {31'b0, OUT_BUSY}, 32'd1);
      checkOutput("mem_we", {31'b0, MEM_WE}, {31'b0, write});
      checkOutput("mem_addr", MEM_ADDR, addr);
      checkOutput("mem_wdata", MEM_WDATA, wdata);
      checkOutput("no_early_done", {31'b0, OUT_DONE}, 32'd0);
    end
    if (give_ack) begin
      MEM_ACK   = 1'b1;
      MEM_RDATA = rdata;
    end
    @(negedge CLOCK_50);
    MEM_ACK   = 1'b0;
    MEM_RDATA = 32'h5A5A_5A5A;
    IN_START  = 1'b0;
    checkOutput("done_pulse", {31'b0, OUT_DONE}, 32'd1);
    checkOutput("req_dropped", {31'b0, MEM_REQ}, 32'd0);
    @(negedge CLOCK_50);
    checkOutput("done_one_cycle", {31'b0, OUT_DONE}, 32'd0);
    checkOutput("select_one_cycle", {31'b0, OUT_SELECT_MEM}, 32'd0);
    checkOutput("idle_not_busy", {31'b0, OUT_BUSY}, 32'd0);
  endtask

  initial begin
    #200000;
    $display("[TB] FAIL watchdog: simulation did not finish in time");
    $fatal(1, "[TB] watchdog expired");
  end

  initial begin
    RESET_InHigh = 1'b1;
    IN_START     = 1'b0;
    IN_WRITE     = 1'b0;
    IN_ADDR      = '0;
    IN_WDATA     = '0;
    MEM_ACK      = 1'b0;
    MEM_RDATA    = '0;
    model_rdata  = '0;
    repeat (2) @(negedge CLOCK_50);
    checkOutput("reset_busy", {31'b0, OUT_BUSY}, 32'd0);
    checkOutput("reset_req", {31'b0, MEM_REQ}, 32'd0);
    checkOutput("reset_done", {31'b0, OUT_DONE}, 32'd0);
    checkOutput("reset_rdata", OUT_RDATA, 32'd0);
    RESET_InHigh = 1'b0;

    $display("[TB] load, store, immediate ack");
    applyStimulus(1'b0, 32'h10, 32'h0, 2, 32'hDEAD_BEEF, 1'b1, 1'b0);
    applyStimulus(1'b1, 32'h20, 32'h1234_5678, 1, 32'h0BAD_F00D, 1'b1, 1'b0);
    applyStimulus(1'b0, 32'h30, 32'h0, 0, 32'hCAFE_F00D, 1'b1, 1'b0);

    $display("[TB] protocol noise");
    @(negedge CLOCK_50);
    MEM_ACK   = 1'b1;
    MEM_RDATA = 32'hFFFF_FFFF;
    repeat (2) begin
      @(negedge CLOCK_50);
      checkOutput("idle_ack_no_done", {31'b0, OUT_DONE}, 32'd0);
      checkOutput("idle_ack_no_busy", {31'b0, OUT_BUSY}, 32'd0);
    end
    MEM_ACK = 1'b0;
    applyStimulus(1'b0, 32'h40, 32'h0, 3, 32'h1357_2468, 1'b1, 1'b1);

    $display("[TB] back-to-back with start and ack held high");
    @(negedge CLOCK_50);
    IN_START = 1'b1;
    IN_WRITE = 1'b0;
    IN_ADDR  = 32'h50;
    MEM_ACK  = 1'b1;
    for (int t = 0; t < 3; t++) begin
      if (t > 0) checkOutput("b2b_idle", {31'b0, OUT_BUSY}, 32'd0);
      model_rdata = 32'hC0DE_0000 + 32'(t);
      exp_q.push_back('{rdata: model_rdata, select: 1'b1, error: 1'b0});
      @(negedge CLOCK_50);
      checkOutput("b2b_req", {31'b0, MEM_REQ}, 32'd1);
      MEM_RDATA = 32'hC0DE_0000 + 32'(t);
      @(negedge CLOCK_50);
      checkOutput("b2b_done", {31'b0, OUT_DONE}, 32'd1);
      MEM_RDATA = 32'h0;
      @(negedge CLOCK_50);
    end
    IN_START = 1'b0;
    MEM_ACK  = 1'b0;

    $display("[TB] reset during REQ");
    @(negedge CLOCK_50);
    IN_START = 1'b1;
    IN_ADDR  = 32'h60;
    @(negedge CLOCK_50);
    IN_START = 1'b0;
    checkOutput("pre_reset_req", {31'b0, MEM_REQ}, 32'd1);
    #2 RESET_InHigh = 1'b1;
    #1;
    checkOutput("async_reset_req", {31'b0, MEM_REQ}, 32'd0);
    checkOutput("async_reset_busy", {31'b0, OUT_BUSY}, 32'd0);
    checkOutput("async_reset_rdata", OUT_RDATA, 32'd0);
    checkOutput("async_reset_addr", MEM_ADDR, 32'd0);
    model_rdata = '0;
    @(negedge CLOCK_50);
    RESET_InHigh = 1'b0;
    @(negedge CLOCK_50);
    checkOutput("reset_no_done", {31'b0, OUT_DONE}, 32'd0);
    applyStimulus(1'b0, 32'h70, 32'h0, 1, 32'h55AA_33CC, 1'b1, 1'b0);

`ifdef MEM_TIMEOUT_EN
    $display("[TB] timeout");
    applyStimulus(1'b0, 32'h80, 32'h0, TO - 1, 32'h1111_1111, 1'b0, 1'b0);
    applyStimulus(1'b0, 32'h90, 32'h0, TO - 1, 32'h2222_2222, 1'b1, 1'b0);
`endif

    repeat (2) @(negedge CLOCK_50);
    checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);
    $display("TB_RESULT checks=%0d failures=%0d", check_count, fail_count);
    $finish;
  end

endmodule

// File: doc/mem_access_unit.md
# mem_access_unit

Sequences single load/store transactions between the datapath and a req/ack memory port. It latches address, write data and direction from the control unit and holds a registered request until memory acknowledges. For loads it captures the returned word into a holding register that feeds the memory input of the C-bus multiplexer, and it drives that multiplexer's select for the write-back cycle.

## Interface
- DATA_WIDTH, 32, width of data words (matches the C-bus width)
- ADDR_WIDTH, 32, width of memory address
- TIMEOUT_CYCLES, 15, maximum cycles spent waiting for MEM_ACK (used only with the timeout feature; legal range 1..255)
- CLOCK_50  input  1  system clock; all logic on the rising edge
- RESET_InHigh  input  1  reset, asynchronous and active-high
- IN_START  input  1  transaction request; sampled only in IDLE
- IN_WRITE  input  1  1 = store, 0 = load; sampled with IN_START
- IN_ADDR  input  ADDR_WIDTH  transaction address; sampled with IN_START
- IN_WDATA  input  DATA_WIDTH  store data from the B bus; sampled with IN_START
- OUT_BUSY  output  1  high in every state except IDLE
- OUT_DONE  output  1  one-cycle completion pulse
- OUT_RDATA  output  DATA_WIDTH  last captured load word, held until the next successful load
- OUT_SELECT_MEM  output  1  C-bus mux select; high only in the DONE cycle of a successful load
- OUT_ERROR  output  1  high with OUT_DONE when the transaction timed out
- MEM_REQ  output  1  memory request
- MEM_WE  output  1  memory write enable
- MEM_ADDR  output  ADDR_WIDTH  memory address
- MEM_WDATA  output  DATA_WIDTH  memory write data
- MEM_ACK  input  1  memory acknowledge, single-cycle
- MEM_RDATA  input  DATA_WIDTH  read data, valid in the MEM_ACK cycle

## Operation
- States: IDLE, REQ, DONE.
- IDLE: on IN_START=1, latch IN_WRITE, IN_ADDR and IN_WDATA into MEM_WE, MEM_ADDR and MEM_WDATA. Set MEM_REQ=1 and go to REQ.
- REQ: MEM_REQ, MEM_WE, MEM_ADDR and MEM_WDATA stay stable. When MEM_ACK=1:
  - if the transaction is a load, capture MEM_RDATA into OUT_RDATA;
  - drop MEM_REQ and go to DONE.
- DONE: OUT_DONE=1. OUT_SELECT_MEM = not MEM_WE and not OUT_ERROR. Return to IDLE.
- IN_START outside IDLE is ignored; there is no queueing.
- MEM_ACK outside REQ is ignored.
- All outputs are registered.
- Reset: state IDLE; every output 0, including OUT_RDATA.
- Reset mid-transaction aborts immediately. MEM_REQ falls asynchronously and no DONE pulse is produced.

## Timing
- IN_START in cycle 0 → MEM_REQ=1 from cycle 1.
- MEM_ACK in cycle k (k≥1) → OUT_DONE and OUT_RDATA valid in cycle k+1.
- Minimum transaction: 3 cycles start-to-IDLE; back-to-back IN_START accepted every 3 cycles.
- MEM_ACK in the first REQ cycle is legal.
- OUT_RDATA is stable from the DONE cycle until the next load's DONE.

## Configuration
- MEM_TIMEOUT_EN defined:
  - an 8-bit counter clears on entry to REQ and increments each REQ cycle without MEM_ACK;
  - when it reaches TIMEOUT_CYCLES: drop MEM_REQ, go to DONE with OUT_ERROR=1, OUT_RDATA unchanged, OUT_SELECT_MEM=0.
  - MEM_ACK in the same cycle as the terminal count wins (normal completion).
- Not defined: REQ waits indefinitely, OUT_ERROR tied to 0, no counter logic.

## Structure
- Shared package: state encoding constants (IDLE=2'd0, REQ=2'd1, DONE=2'd2) and default width constants.
- Sub-module: none for the main path; the timeout counter goes in mem_timeout_counter, instantiated only under MEM_TIMEOUT_EN.

## Test plan
- Load: IN_START, IN_WRITE=0, IN_ADDR=0x10; MEM_ACK two cycles after MEM_REQ with MEM_RDATA=0xDEADBEEF → OUT_RDATA=0xDEADBEEF; OUT_DONE=1 and OUT_SELECT_MEM=1 for exactly one cycle.
- Store: IN_WRITE=1, IN_ADDR=0x20, IN_WDATA=0x12345678 → MEM_WE=1, MEM_ADDR=0x20, MEM_WDATA=0x12345678 stable through REQ. OUT_DONE pulses; OUT_SELECT_MEM stays 0; OUT_RDATA keeps its prior value.
- Immediate ack: MEM_ACK in the first REQ cycle → DONE two cycles after IN_START. IN_START held high continuously → a new transaction every 3 cycles.
- Protocol noise: IN_START during REQ and MEM_ACK during IDLE → no state change and no extra OUT_DONE.
- Reset during REQ → MEM_REQ=0 and all outputs 0 asynchronously. IDLE after release; a subsequent load completes normally.
- With MEM_TIMEOUT_EN and TIMEOUT_CYCLES=4, no ack → OUT_DONE=1 and OUT_ERROR=1 after 4 REQ cycles, OUT_RDATA unchanged. Repeat with MEM_ACK on the 4th cycle → OUT_ERROR=0.
